// File: rtl/glb_axi_rd_master_if.sv
`default_nettype none
// ============================================================================
// Module      : glb_axi_rd_master_if
// Description : DRAM read-address/read-data channel plus GLB SRAM write port
//               used by the GLB read DMA master.
// Revision    : 1.0 - initial release
// ============================================================================
interface glb_axi_rd_master_if #(
  parameter int DW     = 32,
  parameter int AW     = 32,
  parameter int GLB_AW = 12
);
  logic [AW-1:0]     araddr;
  logic [3:0]        arburst;
  logic              arvalid;
  logic              arready;
  logic              rvalid;
  logic [DW-1:0]     rdata;
  logic              rlast;
  logic              glb_we;
  logic [GLB_AW-1:0] glb_waddr;
  logic [DW-1:0]     glb_wdata;

  modport master (
    output araddr, arburst, arvalid,
    input  arready,
    input  rvalid, rdata, rlast,
    output glb_we, glb_waddr, glb_wdata
  );

  modport slave (
    input  araddr, arburst, arvalid,
    output arready,
    output rvalid, rdata, rlast,
    input  glb_we, glb_waddr, glb_wdata
  );
endinterface
`default_nettype wire

// File: rtl/glb_axi_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : glb_axi_rd_master
// Description : Splits a GLB load command into DRAM read bursts and writes
//               every returned beat into the GLB SRAM.
// Revision    : 1.0 - initial release
// ============================================================================
module glb_axi_rd_master #(
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int GLB_AW    = 12,
  parameter int LEN_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              cmd_valid,
  output logic                   cmd_ready,
  input  wire logic [AW-1:0]     cmd_addr,
  input  wire logic [LEN_W-1:0]  cmd_len,
  input  wire logic [GLB_AW-1:0] cmd_glb_addr,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  glb_axi_rd_master_if.master    bus
);

  localparam int BEAT_W     = 5;
  localparam int BYTE_SHIFT = $clog2(DW / 8);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [GLB_AW-1:0]   ptr_q, ptr_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [BEAT_W-1:0]   burst_len_q, burst_len_d;
  logic                glb_we_q, glb_we_d;
  logic [GLB_AW-1:0]   glb_waddr_q, glb_waddr_d;
  logic [DW-1:0]       glb_wdata_q, glb_wdata_d;
  logic                err_q, err_d;
  logic                armed_q, armed_d;
  logic [BEAT_W-1:0]   burst_len_now;
  logic                last_beat;

  assign burst_len_now = (remaining_q > LEN_W'(MAX_BURST)) ? BEAT_W'(MAX_BURST)
                                                           : remaining_q[BEAT_W-1:0];

  assign cmd_ready     = (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign done          = (state_q == S_FIN);
  assign err           = err_q;
  assign bus.arvalid   = (state_q == S_ADDR);
  assign bus.araddr    = addr_q;
  assign bus.arburst   = (state_q == S_ADDR) ? 4'(burst_len_now - BEAT_W'(1)) : 4'd0;
  assign bus.glb_we    = glb_we_q;
  assign bus.glb_waddr = glb_waddr_q;
  assign bus.glb_wdata = glb_wdata_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    ptr_d       = ptr_q;
    beat_cnt_d  = beat_cnt_q;
    burst_len_d = burst_len_q;
    glb_we_d    = 1'b0;
    glb_waddr_d = glb_waddr_q;
    glb_wdata_d = glb_wdata_q;
    err_d       = err_q;
    armed_d     = armed_q;
    last_beat   = (beat_cnt_q == burst_len_q - BEAT_W'(1));

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d      = cmd_addr;
          remaining_d = cmd_len;
          ptr_d       = cmd_glb_addr;
          err_d       = 1'b0;
          armed_d     = 1'b1;
          state_d     = (cmd_len == '0) ? S_FIN : S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.arready) begin
          beat_cnt_d  = '0;
          burst_len_d = burst_len_now;
          state_d     = S_DATA;
        end
      end
      S_DATA: begin
        if (bus.rvalid) begin
          glb_we_d    = 1'b1;
          glb_waddr_d = ptr_q;
          glb_wdata_d = bus.rdata;
          ptr_d       = ptr_q + GLB_AW'(1);
          // rlast is only checked; the beat count alone ends the burst
          if (bus.rlast != last_beat) begin
            err_d = 1'b1;
          end
          if (last_beat) begin
            remaining_d = remaining_q - LEN_W'(burst_len_q);
            addr_d      = addr_q + (AW'(burst_len_q) << BYTE_SHIFT);
            state_d     = (remaining_q == LEN_W'(burst_len_q)) ? S_FIN : S_ADDR;
          end else begin
            beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          end
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Beats outside a burst are dropped; they only count as errors once a
    // command has been accepted since reset.
    if (bus.rvalid && armed_q && (state_q != S_DATA)) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      ptr_q       <= '0;
      beat_cnt_q  <= '0;
      burst_len_q <= '0;
      glb_we_q    <= 1'b0;
      glb_waddr_q <= '0;
      glb_wdata_q <= '0;
      err_q       <= 1'b0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      ptr_q       <= ptr_d;
      beat_cnt_q  <= beat_cnt_d;
      burst_len_q <= burst_len_d;
      glb_we_q    <= glb_we_d;
      glb_waddr_q <= glb_waddr_d;
      glb_wdata_q <= glb_wdata_d;
      err_q       <= err_d;
      armed_q     <= armed_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_glb_axi_rd_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_glb_axi_rd_master
// Description : Bench for glb_axi_rd_master with a DRAM responder and a
//               command-level reference model checked every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_glb_axi_rd_master;
  localparam int DW = 32, AW = 32, GLB_AW = 12, LEN_W = 16, MAXB = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic [AW-1:0]     cmd_addr = '0;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [GLB_AW-1:0] cmd_glb_addr = '0;
  logic              cmd_ready, busy, done, err;

  glb_axi_rd_master_if #(.DW(DW), .AW(AW), .GLB_AW(GLB_AW)) bus ();

  glb_axi_rd_master #(.DW(DW), .AW(AW), .GLB_AW(GLB_AW), .LEN_W(LEN_W), .MAX_BURST(MAXB)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_glb_addr(cmd_glb_addr),
    .busy(busy), .done(done), .err(err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [AW-1:0] addr; logic [3:0] burst; } ar_t;
  typedef struct packed { logic [GLB_AW-1:0] waddr; logic [DW-1:0] wdata; } wr_t;

  int checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // DRAM contents as a pure function of byte address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'h5A3C, a[31:16] + a[15:0]};
  endfunction

  // reference model state
  ar_t  exp_ar_q[$];
  wr_t  exp_wr_q[$];
  ar_t  resp_q[$];
  bit   cmd_active = 0, ar_pending = 0, in_burst = 0, armed = 0, err_exp = 0;
  bit   exp_we, exp_done, ar_prev;
  int   wr_left, beat_idx, beat_len, m_rem, m_b;
  logic [AW-1:0] m_a, p_araddr = '0;
  logic [3:0]    p_arburst = '0;
  logic          p_cmd_ready = 1'b0;
  ar_t  a_pop;
  wr_t  w_pop;

  // observation logs for literal checks
  logic [AW-1:0] ar_addr_log[$];
  logic [3:0]    ar_len_log[$];
  int   wr_count = 0, done_count = 0, cyc = 0, first_arv_cyc = -1, first_we_cyc = -1;
  logic [GLB_AW-1:0] first_waddr = '0;
  logic [DW-1:0]     first_wdata = '0;

  // compare process: samples 1 time unit after every rising edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!rst_n) begin
        exp_ar_q.delete(); exp_wr_q.delete();
        cmd_active = 0; ar_pending = 0; in_burst = 0; armed = 0; err_exp = 0;
        check("reset_ctrl", {bus.arvalid, bus.glb_we, done, busy, err, cmd_ready, bus.arburst}, {6'b000001, 4'h0});
        check("reset_addr", {bus.araddr, bus.glb_waddr}, 64'd0);
        check("reset_wdata", bus.glb_wdata, 64'd0);
      end else begin
        exp_we = 0; exp_done = 0; ar_prev = ar_pending;
        if (p_cmd_ready && cmd_valid) begin
          armed = 1; err_exp = 0; cmd_active = 1; wr_left = int'(cmd_len);
          m_a = cmd_addr; m_rem = int'(cmd_len);
          while (m_rem > 0) begin
            m_b = (m_rem > MAXB) ? MAXB : m_rem;
            exp_ar_q.push_back('{addr: m_a, burst: 4'(m_b - 1)});
            m_a = m_a + 32'(m_b * 4);
            m_rem = m_rem - m_b;
          end
          for (int i = 0; i < int'(cmd_len); i++)
            exp_wr_q.push_back('{waddr: GLB_AW'(int'(cmd_glb_addr) + i), wdata: mem_word(cmd_addr + 32'(i * 4))});
          if (cmd_len == 0) exp_done = 1;
          else ar_pending = 1;
        end
        if (bus.rvalid) begin
          if (in_burst) begin
            exp_we = 1;
            if (bus.rlast != (beat_idx == beat_len - 1)) err_exp = 1;
            beat_idx++; wr_left--;
            if (beat_idx == beat_len) begin
              in_burst = 0;
              if (wr_left > 0) ar_pending = 1;
              else exp_done = 1;
            end
          end else if (armed) begin
            err_exp = 1;
          end
        end
        if (ar_prev && bus.arready) begin
          a_pop = (exp_ar_q.size() > 0) ? exp_ar_q.pop_front() : '0;
          ar_pending = 0; in_burst = 1; beat_idx = 0; beat_len = int'(a_pop.burst) + 1;
          resp_q.push_back('{addr: p_araddr, burst: p_arburst});
          ar_addr_log.push_back(p_araddr); ar_len_log.push_back(p_arburst);
        end
        check("glb_we", bus.glb_we, exp_we);
        if (exp_we) begin
          w_pop = (exp_wr_q.size() > 0) ? exp_wr_q.pop_front() : '0;
          check("glb_waddr", bus.glb_waddr, w_pop.waddr);
          check("glb_wdata", bus.glb_wdata, w_pop.wdata);
          if (wr_count == 0) begin
            first_waddr = bus.glb_waddr; first_wdata = bus.glb_wdata; first_we_cyc = cyc;
          end
          wr_count++;
        end
        check("done", done, exp_done);
        check("busy", busy, cmd_active);
        check("cmd_ready", cmd_ready, !cmd_active);
        check("err", err, err_exp);
        check("arvalid", bus.arvalid, ar_pending);
        if (ar_pending && exp_ar_q.size() > 0) begin
          check("araddr", bus.araddr, exp_ar_q[0].addr);
          check("arburst", bus.arburst, exp_ar_q[0].burst);
        end
        if (bus.arvalid && first_arv_cyc < 0) first_arv_cyc = cyc;
        if (exp_done) begin cmd_active = 0; done_count++; end
      end
      p_cmd_ready = cmd_ready; p_araddr = bus.araddr; p_arburst = bus.arburst;
    end
  end

  // DRAM responder
  int   stall_left = 0, inj_idx = -1, r_idx = 0;
  bit   rand_ar = 0, rand_gap = 0, r_act = 0;
  ar_t  cur;

  initial begin
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rlast = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_left > 0 && bus.arvalid) begin
        bus.arready = 1'b0;
        stall_left--;
      end else begin
        bus.arready = rand_ar ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (!r_act && resp_q.size() > 0) begin
        cur = resp_q.pop_front(); r_act = 1; r_idx = 0;
      end
      if (r_act && !(rand_gap && $urandom_range(0, 2) == 0)) begin
        bus.rvalid = 1'b1;
        bus.rdata  = mem_word(cur.addr + 32'(r_idx * 4));
        bus.rlast  = (r_idx == int'(cur.burst)) || (r_idx == inj_idx);
        r_idx++;
        if (r_idx > int'(cur.burst)) r_act = 0;
      end else begin
        bus.rvalid = 1'b0;
        bus.rlast  = 1'b0;
      end
    end
  end

  task automatic issue(input logic [31:0] a, input int len, input logic [11:0] g);
    int n = 0;
    ar_addr_log.delete(); ar_len_log.delete();
    wr_count = 0; done_count = 0; first_arv_cyc = -1; first_we_cyc = -1;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = LEN_W'(len); cmd_glb_addr = g;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (done_count == 0 && n < limit) begin @(negedge clk); n++; end
    check("done_timeout", done_count != 0, 1);
  endtask

  task automatic check_ar(input string nm, input int i, input logic [31:0] a, input logic [3:0] b);
    if (ar_addr_log.size() > i) begin
      check({nm, "_addr"}, ar_addr_log[i], a);
      check({nm, "_burst"}, ar_len_log[i], b);
    end else begin
      check({nm, "_missing"}, 0, 1);
    end
  endtask

  initial begin
    int n;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    rst_n = 1'b1;

    // single short burst
    issue(32'h1000, 5, 12'h010);
    wait_done(100);
    check("t1_ar_count", ar_addr_log.size(), 1);
    check_ar("t1_ar0", 0, 32'h1000, 4'd4);
    check("t1_wr_count", wr_count, 5);
    check("t1_first_waddr", first_waddr, 12'h010);
    check("t1_first_wdata", first_wdata, 32'h4A3C_1000);
    check("t1_err", err, 0);

    // multi-burst split
    issue(32'h1000, 40, 12'h100);
    wait_done(300);
    repeat (3) @(negedge clk);
    check("t2_ar_count", ar_addr_log.size(), 3);
    check_ar("t2_ar0", 0, 32'h1000, 4'd15);
    check_ar("t2_ar1", 1, 32'h1040, 4'd15);
    check_ar("t2_ar2", 2, 32'h1080, 4'd7);
    check("t2_wr_count", wr_count, 40);
    check("t2_done_count", done_count, 1);

    // address stall
    stall_left = 10;
    issue(32'h2000, 8, 12'h200);
    wait_done(200);
    check("t3_ar_count", ar_addr_log.size(), 1);
    check_ar("t3_ar0", 0, 32'h2000, 4'd7);
    check("t3_stall_gap", (first_we_cyc - first_arv_cyc) >= 12, 1);

    // zero length
    issue(32'h3000, 0, 12'h300);
    wait_done(20);
    @(negedge clk);
    check("t4_ready_after", cmd_ready, 1);
    check("t4_ar_count", ar_addr_log.size(), 0);
    check("t4_wr_count", wr_count, 0);

    // protocol error: rlast on beat 2 of 4
    inj_idx = 1;
    issue(32'h4000, 4, 12'h400);
    wait_done(100);
    inj_idx = -1;
    check("t5_err_set", err, 1);
    check("t5_wr_count", wr_count, 4);
    issue(32'h5000, 3, 12'h410);
    check("t5_err_cleared", err, 0);
    wait_done(100);

    // reset in the middle of a 16-beat burst
    issue(32'h6000, 16, 12'h500);
    n = 0;
    while (wr_count < 3 && n < 100) begin @(negedge clk); n++; end
    check("t6_reached_beat3", wr_count, 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("t6_post_reset", {cmd_ready, busy, bus.arvalid, bus.glb_we}, 4'b1000);
    repeat (25) @(negedge clk);
    check("t6_no_more_writes", wr_count, 3);
    check("t6_err_clear", err, 0);

    // randomized commands with random arready and beat gaps
    rand_ar = 1; rand_gap = 1;
    for (int k = 0; k < 10; k++) begin
      logic [31:0] ra;
      ra = (k % 3 == 2) ? 32'hFFFF_FFC0 : ($urandom & 32'hFFFF_FFFC);
      issue(ra, int'($urandom_range(0, 50)), 12'($urandom));
      wait_done(3000);
    end
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
